// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO burst reader.
// Imported by the buffer, the interface users and the top.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } rd_state_e;

  localparam int RD_BUF_DEPTH = 3;

  // Counter width for a modulo-n index; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus downstream valid/ready stream.
// master = the reader, slave = FIFO and consumer side.
interface fifo_burst_reader_if #(
  parameter int WIDTH = 8
);

  logic             fifo_r_en;
  logic [WIDTH-1:0] fifo_r_data;
  logic             fifo_empty;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output fifo_r_en,
    input  fifo_r_data,
    input  fifo_empty,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  fifo_r_en,
    output fifo_r_data,
    output fifo_empty,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/rd_skid_buf.sv
// Three-entry circular buffer between FIFO capture and stream.
// Head is combinational from storage; occupancy is registered.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  localparam logic [1:0] LAST_SLOT = 2'(RD_BUF_DEPTH - 1);
  localparam logic [1:0] FULL = 2'(RD_BUF_DEPTH);

  logic [WIDTH-1:0] mem [0:RD_BUF_DEPTH-1];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == LAST_SLOT) ? 2'd0 : p + 2'd1;
  endfunction

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push/pop holds occ.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      assert (!(push && occ == FULL))
        else $error("rd_skid_buf push while full");
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case (1'b1)
        push && !pop: occ <= occ + 2'd1;
        pop && !push: occ <= occ - 2'd1;
        default:      occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a 1-cycle-latency FIFO into a burst-framed stream.
// Read issue looks only at registered state and fifo_empty.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  fifo_burst_reader_if.master bus,
  output logic               busy,
  output logic [COUNT_W-1:0] word_count
);

  localparam int IW = cnt_w(BURST_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(BURST_LEN - 1);

  rd_state_e   state;
  logic        inflight;
  logic [IW-1:0] iss_idx;
  logic [IW-1:0] beat_idx;
  logic [1:0]  occ;
  logic [2:0]  pending;
  logic        issue_ok;
  logic        rd;
  logic        pop;
  logic        drained;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] v);
    return (v == LAST_IDX) ? '0 : v + 1'b1;
  endfunction

  assign pending  = {1'b0, occ} + {2'b00, inflight};
  assign issue_ok = (state == RUN) ||
                    (state == STOP && iss_idx != '0);
  assign rd       = !bus.fifo_empty && issue_ok &&
                    (pending < 3'(RD_BUF_DEPTH));
  assign drained  = (iss_idx == '0) && !inflight && (occ == 2'd0);

  assign bus.fifo_r_en = rd;
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_last  = bus.out_valid && (beat_idx == LAST_IDX);
  assign pop           = bus.out_valid && bus.out_ready;

  rd_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight),
    .push_data (bus.fifo_r_data),
    .pop       (pop),
    .occ       (occ),
    .head      (bus.out_data)
  );

  // Run/stop sequencing; a started burst is finished before IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!en) state <= STOP;
        end
        STOP: begin
          if (en) begin
            state <= RUN;
          end else if (drained) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Issue tracking and read-data capture strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= 1'b0;
      iss_idx  <= '0;
    end else begin
      inflight <= rd;
      if (rd) iss_idx <= inc(iss_idx);
    end
  end

  // Accepted-beat framing and running word count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_idx   <= '0;
      word_count <= '0;
    end else if (pop) begin
      beat_idx   <= inc(beat_idx);
      word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed/random bench for fifo_burst_reader with a FIFO model
// and an in-order scoreboard of pushed words.
module tb_fifo_burst_reader;

  localparam int W  = 8;
  localparam int BL = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rstn;
  logic          en;
  logic          busy;
  logic [CW-1:0] word_count;

  fifo_burst_reader_if #(.WIDTH(W)) bus ();

  fifo_burst_reader #(
    .WIDTH     (W),
    .BURST_LEN (BL),
    .COUNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .bus        (bus),
    .busy       (busy),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: 1-cycle read latency, flushed by rstn.
  logic [W-1:0] fmem [0:255];
  logic [7:0]   wr_ptr;
  logic [7:0]   rd_ptr;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr          <= wr_ptr;
      bus.fifo_r_data <= '0;
    end else if (bus.fifo_r_en) begin
      bus.fifo_r_data <= fmem[rd_ptr];
      rd_ptr          <= rd_ptr + 8'd1;
    end
  end

  int           tests;
  int           fails;
  logic [W-1:0] exp_q [$];
  int           acc;
  int           iss;
  int           lasts;
  logic         seen_valid;
  logic         hold;
  logic [W-1:0] hold_data;
  logic         hold_last;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    fmem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(d);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_word(W'($urandom));
  endtask

  // Observe the cycle whose inputs are now settled, then advance.
  task automatic tick();
    #1;
    seen_valid = bus.out_valid;
    if (hold) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, hold_data);
      check("hold_last", bus.out_last, hold_last);
    end
    if (bus.fifo_r_en) begin
      check("r_en_room", (iss - acc) < 3, 1);
      check("r_en_empty", bus.fifo_empty, 0);
      iss++;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 1, 0);
      end else begin
        check("beat_data", bus.out_data, exp_q[0]);
        check("beat_last", bus.out_last, (acc % BL) == BL - 1);
        void'(exp_q.pop_front());
      end
      if (bus.out_last) lasts++;
      acc++;
    end
    hold      = bus.out_valid && !bus.out_ready;
    hold_data = bus.out_data;
    hold_last = bus.out_last;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    en = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_r_en", bus.fifo_r_en, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_count", word_count, 0);
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    acc = 0;
    iss = 0;
    lasts = 0;
    hold = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    en = 1'b0;
    for (int i = 0; i < 30 && busy; i++) tick();
    check(tag, busy, 0);
  endtask

  initial begin
    int first;
    tests = 0;
    fails = 0;
    wr_ptr = 8'd0;
    hold = 1'b0;
    do_reset();

    // Eight preloaded words, always ready.
    push_rand(8);
    en = 1'b1;
    bus.out_ready = 1'b1;
    first = -1;
    for (int c = 0; c < 11; c++) begin
      tick();
      if (seen_valid && first < 0) first = c;
    end
    check("first_beat_cycle", first, 3);
    check("t1_beats", acc, 8);
    check("t1_lasts", lasts, 2);
    check("t1_count", word_count, acc % (1 << CW));
    wait_idle("t1_idle");

    // Ready toggling 1-0-1-0 over six words.
    do_reset();
    push_rand(6);
    en = 1'b1;
    for (int c = 0; c < 40 && acc < 6; c++) begin
      bus.out_ready = (c % 2) == 0;
      tick();
    end
    check("t2_beats", acc, 6);
    check("t2_left", exp_q.size(), 0);

    // Mid-burst starvation keeps framing.
    do_reset();
    push_rand(2);
    en = 1'b1;
    bus.out_ready = 1'b1;
    run(10);
    check("t3_beats_a", acc, 2);
    check("t3_lasts_a", lasts, 0);
    check("t3_dry_valid", bus.out_valid, 0);
    check("t3_busy", busy, 1);
    push_rand(2);
    run(10);
    check("t3_beats_b", acc, 4);
    check("t3_lasts_b", lasts, 1);
    wait_idle("t3_idle");

    // Stop after one issued read finishes the burst.
    do_reset();
    push_rand(10);
    en = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && iss == 0; c++) tick();
    en = 1'b0;
    run(30);
    check("t4_beats", acc, 4);
    check("t4_busy", busy, 0);
    check("t4_fifo_left", 32'(wr_ptr - rd_ptr), 6);

    // Reset with two buffered and one in flight.
    do_reset();
    push_rand(10);
    en = 1'b1;
    bus.out_ready = 1'b0;
    run(4);
    check("t5_issued", iss, 3);
    check("t5_valid_pre", bus.out_valid, 1);
    do_reset();
    push_rand(3);
    en = 1'b1;
    bus.out_ready = 1'b1;
    run(10);
    check("t5_beats", acc, 3);
    check("t5_lasts", lasts, 0);
    check("t5_count", word_count, 3);

    // Counter wrap at 2^CW.
    do_reset();
    push_rand(17);
    en = 1'b1;
    bus.out_ready = 1'b1;
    run(25);
    check("t6_beats", acc, 17);
    check("t6_wrap", word_count, acc % (1 << CW));
    check("t6_lasts", lasts, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
